// File: rtl/wb_commit_unit_pkg.sv
// ============================================================================
// Module   : wb_commit_unit_pkg
// Purpose  : Shared widths and the write-source type for the commit unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_commit_unit_pkg;

  localparam int unsigned XLEN_DEFAULT        = 32;
  localparam int unsigned RFIDX_WIDTH_DEFAULT = 5;
  localparam int unsigned LQ_DEPTH_DEFAULT    = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_load_queue.sv
// ============================================================================
// Module   : wb_load_queue
// Purpose  : Synchronous FIFO for load results waiting for the write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_queue #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/wb_commit_unit.sv
// ============================================================================
// Module   : wb_commit_unit
// Purpose  : Merges ALU and load results onto the single regfile write port
//            and tracks pending destination registers for hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter int unsigned RFIDX_WIDTH = RFIDX_WIDTH_DEFAULT,
  parameter int unsigned LQ_DEPTH    = LQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [RFIDX_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic                   issue_valid,
  input  logic [RFIDX_WIDTH-1:0] issue_rd,
  input  logic [RFIDX_WIDTH-1:0] rs1_addr,
  input  logic [RFIDX_WIDTH-1:0] rs2_addr,
  input  logic [RFIDX_WIDTH-1:0] rd_addr,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rd_busy,
  output logic [RFIDX_WIDTH-1:0] write_addr,
  output logic [XLEN-1:0]        write_data,
  output logic                   reg_write
);

  localparam int unsigned NREGS = 1 << RFIDX_WIDTH;
  localparam int unsigned LQ_W  = RFIDX_WIDTH + XLEN;

  logic                   w_alu_take;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [LQ_W-1:0]        w_lq_head;
  wb_src_e                w_src;

  logic                   reg_write_q,  reg_write_d;
  logic [RFIDX_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]        write_data_q, write_data_d;
  logic [NREGS-1:0]       sb_q,         sb_d;

  // x0 loads complete the handshake but never occupy a queue slot.
  assign w_alu_take = alu_valid && (alu_rd != '0);
  assign lsu_ready  = !w_full;
  assign w_push     = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign w_pop      = (w_src == SRC_LOAD);

  wb_load_queue #(
    .WIDTH (LQ_W),
    .DEPTH (LQ_DEPTH)
  ) u_load_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .din_i   ({lsu_rd, lsu_data}),
    .pop_i   (w_pop),
    .dout_o  (w_lq_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    if (w_alu_take)    w_src = SRC_ALU;
    else if (!w_empty) w_src = SRC_LOAD;
    else               w_src = SRC_NONE;
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    case (w_src)
      SRC_ALU: begin
        reg_write_d  = 1'b1;
        write_addr_d = alu_rd;
        write_data_d = alu_data;
      end
      SRC_LOAD: begin
        reg_write_d                  = 1'b1;
        {write_addr_d, write_data_d} = w_lq_head;
      end
      default: ;
    endcase
  end

  // Clear for the committing register first so a same-edge issue re-sets it.
  always_comb begin
    sb_d = sb_q;
    if (reg_write_q) sb_d[write_addr_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      sb_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      sb_q         <= sb_d;
    end
  end

  assign rs1_busy   = sb_q[rs1_addr] && (rs1_addr != '0);
  assign rs2_busy   = sb_q[rs2_addr] && (rs2_addr != '0);
  assign rd_busy    = sb_q[rd_addr]  && (rd_addr  != '0);

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
// ============================================================================
// Module   : tb_wb_commit_unit
// Purpose  : Scoreboard bench for wb_commit_unit with a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_commit_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [RW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            lsu_valid = 1'b0;
  logic            lsu_ready;
  logic [RW-1:0]   lsu_rd = '0;
  logic [XLEN-1:0] lsu_data = '0;
  logic            issue_valid = 1'b0;
  logic [RW-1:0]   issue_rd = '0;
  logic [RW-1:0]   rs1_addr = '0;
  logic [RW-1:0]   rs2_addr = '0;
  logic [RW-1:0]   rd_addr = '0;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic [RW-1:0]   write_addr;
  logic [XLEN-1:0] write_data;
  logic            reg_write;

  wb_commit_unit #(
    .XLEN        (XLEN),
    .RFIDX_WIDTH (RW),
    .LQ_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .reg_write   (reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              we;
    logic [RW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  typedef struct {
    bit ready;
    bit b1;
    bit b2;
    bit bd;
  } st_t;

  wr_t wq[$];        // expected write-port state, one per cycle
  st_t sq[$];        // expected ready/busy, one per cycle
  wr_t mq[$];        // model of loads waiting for the port
  bit  pend[32];     // model of registers with an outstanding write
  wr_t prev_w;
  bit  mon_en = 1'b0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the model's view of what it causes.
  task automatic drive(input bit av, input logic [RW-1:0] ard, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [RW-1:0] lrd, input logic [XLEN-1:0] ld,
                       input bit iv, input logic [RW-1:0] ird,
                       input logic [RW-1:0] q1, input logic [RW-1:0] q2, input logic [RW-1:0] qd,
                       output bit acc);
    wr_t nw;
    st_t st;
    @(posedge clk);
    #1;
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    rs1_addr = q1; rs2_addr = q2; rd_addr = qd;

    st.ready = (mq.size() < DEPTH);
    st.b1    = (q1 != 0) && pend[q1];
    st.b2    = (q2 != 0) && pend[q2];
    st.bd    = (qd != 0) && pend[qd];
    sq.push_back(st);
    acc = lv && st.ready;

    if (av && ard != 0) begin
      nw = '{we: 1'b1, addr: ard, data: ad};
    end else if (mq.size() > 0) begin
      nw = mq.pop_front();
    end else begin
      nw = '{we: 1'b0, addr: prev_w.addr, data: prev_w.data};
    end
    if (acc && lrd != 0) mq.push_back('{we: 1'b1, addr: lrd, data: ld});

    if (prev_w.we) pend[prev_w.addr] = 1'b0;
    if (iv && ird != 0) pend[ird] = 1'b1;
    prev_w = nw;
    wq.push_back(nw);
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n, input logic [RW-1:0] q);
    bit a;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, q, q, q, a);
  endtask

  wr_t m_e;
  st_t m_s;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (wq.size() == 0 || sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        m_e = wq.pop_front();
        m_s = sq.pop_front();
        chk("reg_write", {31'd0, reg_write}, {31'd0, m_e.we});
        if (m_e.we) begin
          chk("write_addr", {27'd0, write_addr}, {27'd0, m_e.addr});
          chk("write_data", write_data, m_e.data);
        end
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_s.ready});
        chk("rs1_busy",  {31'd0, rs1_busy},  {31'd0, m_s.b1});
        chk("rs2_busy",  {31'd0, rs2_busy},  {31'd0, m_s.b2});
        chk("rd_busy",   {31'd0, rd_busy},   {31'd0, m_s.bd});
      end
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_reg_write"}, {31'd0, reg_write}, 32'd0);
    chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd1);
    chk({tag, "_busy"}, {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
  endtask

  initial begin
    bit acc;
    bit lv;
    logic [RW-1:0]   lrd;
    logic [XLEN-1:0] ld;
    bit alu_hi;

    prev_w = '{we: 1'b0, addr: '0, data: '0};
    wq.push_back(prev_w);
    rs1_addr = 5'd3; rs2_addr = 5'd7; rd_addr = 5'd9;
    #12;
    reset_check("por");
    chk("por_write_addr", {27'd0, write_addr}, 32'd0);
    chk("por_write_data", write_data, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // ALU path with scoreboard set/clear
    drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 5, acc);
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5, 5, acc);
    idle(3, 5);

    // ALU/LSU contention and in-order drain behind continuous ALU writes
    drive(1, 3, 32'h3333_0003, 1, 7, 32'h7777_0007, 0, 0, 3, 7, 0, acc);
    for (int i = 0; i < 3; i++)
      drive(1, RW'(1 + i % 2), 32'hA000 + i, 1, RW'(8 + i), 32'h800 + i, 0, 0, 8, 9, 10, acc);
    drive(1, 2, 32'hA0A0, 0, 0, 0, 0, 0, 8, 9, 10, acc);
    idle(6, 8);

    // Fill the queue under ALU traffic; a fifth load waits for a free slot
    for (int i = 0; i < DEPTH; i++)
      drive(1, 1, 32'hB000 + i, 1, RW'(11 + i), 32'hC000 + i, 0, 0, 0, 0, 0, acc);
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++)
      drive(t < 2, 2, 32'hB100 + t, 1, 15, 32'hF15, 0, 0, 0, 0, 0, acc);
    chk("fifth_load_accepted", {31'd0, acc}, 32'd1);
    idle(8, 0);

    // x0 destinations on every input
    drive(1, 0, 32'h1111, 1, 0, 32'h2222, 1, 0, 0, 0, 0, acc);
    drive(1, 0, 32'h3333, 0, 0, 0, 1, 0, 0, 0, 0, acc);
    idle(3, 0);

    // Commit and re-issue of the same register on one edge
    drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 4, 4, acc);
    drive(1, 4, 32'h4444, 0, 0, 0, 0, 0, 4, 4, 4, acc);
    drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 4, 4, acc);
    idle(3, 4);

    // Reset in the middle of traffic with three loads queued
    drive(0, 0, 0, 0, 0, 0, 1, 20, 0, 0, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 1, 21, 0, 0, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 1, 22, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 32'hD000 + i, 1, RW'(20 + i), 32'hE000 + i, 0, 0, 20, 21, 22, acc);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b0; issue_valid = 1'b0;
    rs1_addr = 5'd20; rs2_addr = 5'd21; rd_addr = 5'd22;
    #2 rst_n = 1'b0;
    #1 reset_check("async_rst");
    wq.delete(); sq.delete(); mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    prev_w = '{we: 1'b0, addr: '0, data: '0};
    wq.push_back(prev_w);
    alu_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_check("held_rst");
    #2 rst_n = 1'b1;
    idle(6, 20);

    // Randomized traffic with bursty ALU activity
    lv = 1'b0; lrd = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      bit av, iv;
      alu_hi = ((i / 40) % 2) == 1;
      if (!lv && ($urandom_range(0, 2) != 0)) begin
        lv  = 1'b1;
        lrd = RW'($urandom_range(0, 7));
        ld  = $urandom;
      end
      av = alu_hi ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      iv = ($urandom_range(0, 1) == 1);
      drive(av, RW'($urandom_range(0, 7)), $urandom, lv, lrd, ld,
            iv, RW'($urandom_range(0, 7)),
            RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), acc);
      if (acc) lv = 1'b0;
    end
    idle(10, 0);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
